// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: drives the select input of the downstream glitch-free clock mux.
// Qualifies that the target clock has been continuously healthy, flips the
// select, then holds off until the mux enable handshake has settled.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a software request or an automatic failover
// ST_QUAL   | counting consecutive healthy cycles of the target clock
// ST_SETTLE | select changed, waiting for the mux handshake to complete
module clk_sel_ctrl #(
    parameter int STABLE_CYC  = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_req_sel,
    input  logic i_auto_en,
    input  logic i_clk0_ok,
    input  logic i_clk1_ok,
    output logic o_sel,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_TC  = 8'(STABLE_CYC);
    localparam logic [7:0] SETTLE_TC  = 8'(SETTLE_CYC);
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT_CYC);

    state_t     state_q, state_n;
    logic       target_q, target_n;
    logic [7:0] stab_q, stab_n;
    logic [7:0] tmo_q, tmo_n;
    logic [7:0] settle_q, settle_n;
    logic       sel_q, sel_n;
    logic       busy_q;
    logic       done_q, done_n;
    logic       err_q, err_n;

    logic       cur_ok, alt_ok, tgt_ok;
    logic [7:0] stab_inc, tmo_inc, settle_inc;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        state_n    = state_q;
        target_n   = target_q;
        stab_n     = stab_q;
        tmo_n      = tmo_q;
        settle_n   = settle_q;
        sel_n      = sel_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        cur_ok     = sel_q    ? i_clk1_ok : i_clk0_ok;
        alt_ok     = sel_q    ? i_clk0_ok : i_clk1_ok;
        tgt_ok     = target_q ? i_clk1_ok : i_clk0_ok;
        stab_inc   = tgt_ok ? sat_inc(stab_q) : 8'd0;
        tmo_inc    = sat_inc(tmo_q);
        settle_inc = sat_inc(settle_q);

        case (state_q)
            ST_IDLE: begin
                if (i_req && (i_req_sel == sel_q)) begin
                    // Already on the requested source: acknowledge only.
                    done_n = 1'b1;
                end else if (i_req) begin
                    target_n = i_req_sel;
                    stab_n   = 8'd0;
                    tmo_n    = 8'd0;
                    settle_n = 8'd0;
                    state_n  = ST_QUAL;
                end else if (i_auto_en && !cur_ok && alt_ok) begin
                    target_n = ~sel_q;
                    stab_n   = 8'd0;
                    tmo_n    = 8'd0;
                    settle_n = 8'd0;
                    state_n  = ST_QUAL;
                end
            end
            ST_QUAL: begin
                stab_n = stab_inc;
                tmo_n  = tmo_inc;
                // Stability is checked first so it wins a same-cycle tie.
                if (stab_inc == STABLE_TC) begin
                    sel_n    = target_q;
                    stab_n   = 8'd0;
                    tmo_n    = 8'd0;
                    settle_n = 8'd0;
                    state_n  = ST_SETTLE;
                end else if (tmo_inc == TIMEOUT_TC) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                settle_n = settle_inc;
                if (settle_inc == SETTLE_TC) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            target_q <= 1'b0;
            stab_q   <= 8'd0;
            tmo_q    <= 8'd0;
            settle_q <= 8'd0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            target_q <= target_n;
            stab_q   <= stab_n;
            tmo_q    <= tmo_n;
            settle_q <= settle_n;
            sel_q    <= sel_n;
            busy_q   <= (state_n != ST_IDLE);
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    assign o_sel  = sel_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: directed scenarios followed by random traffic, compared
// cycle by cycle against a timeline model derived from the switching rules.
module tb_clk_sel_ctrl;

    localparam int STABLE_CYC  = 8;
    localparam int SETTLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 64;
    localparam int SEG         = 120;
    localparam int NSEG        = 8;
    localparam int RND0        = SEG * NSEG;
    localparam int L           = 3400;

    logic clk = 1'b0;
    logic rst_i, req_i, req_sel_i, auto_i, ok0_i, ok1_i;
    logic sel_o, busy_o, done_o, err_o;

    bit       s_rst[0:L];
    bit       s_req[0:L];
    bit       s_rsel[0:L];
    bit       s_auto[0:L];
    bit       s_ok0[0:L];
    bit       s_ok1[0:L];
    bit [3:0] exp_o[0:L];
    bit       vld[0:L];
    bit [3:0] obs_o[0:L];

    int n_chk = 0;
    int n_err = 0;

    clk_sel_ctrl #(
        .STABLE_CYC (STABLE_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst_i),
        .i_req    (req_i),
        .i_req_sel(req_sel_i),
        .i_auto_en(auto_i),
        .i_clk0_ok(ok0_i),
        .i_clk1_ok(ok1_i),
        .o_sel    (sel_o),
        .o_busy   (busy_o),
        .o_done   (done_o),
        .o_err    (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void put(int c, bit s, bit b, bit d, bit e);
        if (c <= L) begin
            exp_o[c] = {s, b, d, e};
            vld[c]   = 1'b1;
        end
    endfunction

    function automatic bit okv(bit s, int c);
        return s ? s_ok1[c] : s_ok0[c];
    endfunction

    // Walk the stimulus timeline one transaction at a time.
    task automatic build_model();
        int c, k, m, run, outcome;
        bit s, tgt, stop;
        c = 0;
        s = 1'b0;
        while (c < L) begin
            if (s_rst[c]) begin
                s = 1'b0;
                put(c + 1, 0, 0, 0, 0);
                c = c + 1;
            end else if (s_req[c] && (s_rsel[c] == s)) begin
                put(c + 1, s, 0, 1, 0);
                c = c + 1;
            end else if (s_req[c] || (s_auto[c] && !okv(s, c) && okv(!s, c))) begin
                tgt = s_req[c] ? s_rsel[c] : !s;
                run = 0;
                outcome = 0;
                k = c + 1;
                while (outcome == 0) begin
                    if (k >= L) outcome = 4;
                    else begin
                        put(k, s, 1, 0, 0);
                        if (s_rst[k]) outcome = 3;
                        else begin
                            run = okv(tgt, k) ? run + 1 : 0;
                            if (run == STABLE_CYC) outcome = 1;
                            else if (k - c == TIMEOUT_CYC) outcome = 2;
                            else k = k + 1;
                        end
                    end
                end
                case (outcome)
                    4: begin
                        put(L, s, 1, 0, 0);
                        c = L;
                    end
                    3: begin
                        s = 1'b0;
                        put(k + 1, 0, 0, 0, 0);
                        c = k + 1;
                    end
                    2: begin
                        put(k + 1, s, 0, 0, 1);
                        c = k + 1;
                    end
                    default: begin
                        s = tgt;
                        m = k + 1;
                        stop = 1'b0;
                        while (!stop) begin
                            if (m == k + SETTLE_CYC + 1) begin
                                put(m, s, 0, 1, 0);
                                c = m;
                                stop = 1'b1;
                            end else if (m >= L) begin
                                put(m, s, 1, 0, 0);
                                c = L;
                                stop = 1'b1;
                            end else begin
                                put(m, s, 1, 0, 0);
                                if (s_rst[m]) begin
                                    s = 1'b0;
                                    put(m + 1, 0, 0, 0, 0);
                                    c = m + 1;
                                    stop = 1'b1;
                                end else m = m + 1;
                            end
                        end
                    end
                endcase
            end else begin
                put(c + 1, s, 0, 0, 0);
                c = c + 1;
            end
        end
    endtask

    task automatic build_stim();
        int c, mode;
        bit ae;
        for (int i = 0; i < NSEG; i++) begin
            for (int r = 0; r < SEG; r++) begin
                c = i * SEG + r;
                s_rst[c] = (r == 0);
                s_req[c] = 1'b0; s_rsel[c] = 1'b0; s_auto[c] = 1'b0;
                s_ok0[c] = 1'b0; s_ok1[c] = 1'b0;
                case (i)
                    0: s_rst[c] = (r < 20);
                    1: begin
                        s_ok0[c] = 1; s_ok1[c] = 1;
                        s_req[c] = (r == 10) || (r == 25); s_rsel[c] = (r == 10);
                    end
                    2: begin
                        s_ok0[c] = 1; s_ok1[c] = !((r == 14) || (r == 15));
                        s_req[c] = (r == 10); s_rsel[c] = 1;
                    end
                    3: begin
                        s_ok0[c] = 1; s_req[c] = (r == 10); s_rsel[c] = 1;
                    end
                    4: begin
                        s_auto[c] = 1; s_ok1[c] = 1; s_ok0[c] = (r < 10);
                    end
                    5: begin
                        s_ok1[c] = 1; s_ok0[c] = (r < 10);
                    end
                    6: begin
                        s_ok0[c] = 1; s_ok1[c] = 1; s_req[c] = (r == 10);
                    end
                    default: begin
                        s_ok0[c] = 1; s_ok1[c] = 1;
                        s_req[c] = (r == 10); s_rsel[c] = 1;
                        s_rst[c] = (r == 0) || (r == 25);
                    end
                endcase
            end
        end
        mode = 0;
        ae = 1'b0;
        for (int cc = RND0; cc <= L; cc++) begin
            if ((cc - RND0) % 40 == 0) begin
                mode = $urandom_range(0, 3);
                ae   = 1'($urandom_range(0, 1));
            end
            case (mode)
                0: begin s_ok0[cc] = 1; s_ok1[cc] = 1; end
                1: begin s_ok0[cc] = 1; s_ok1[cc] = ($urandom_range(0, 9) == 0); end
                2: begin s_ok0[cc] = ($urandom_range(0, 9) == 0); s_ok1[cc] = 1; end
                default: begin
                    s_ok0[cc] = ($urandom_range(0, 7) != 0);
                    s_ok1[cc] = ($urandom_range(0, 7) != 0);
                end
            endcase
            s_auto[cc] = ae;
            s_req[cc]  = ($urandom_range(0, 15) == 0);
            s_rsel[cc] = 1'($urandom_range(0, 1));
            s_rst[cc]  = (cc == RND0) || ($urandom_range(0, 599) == 0);
        end
    endtask

    task automatic drive(input int c);
        rst_i     = s_rst[c];
        req_i     = s_req[c];
        req_sel_i = s_rsel[c];
        auto_i    = s_auto[c];
        ok0_i     = s_ok0[c];
        ok1_i     = s_ok1[c];
    endtask

    // Bit positions in obs_o: 3=sel 2=busy 1=done 0=err.
    function automatic bit ob(int i, int r, int b);
        bit [3:0] v;
        v = obs_o[i * SEG + r];
        return v[b];
    endfunction

    initial begin
        build_stim();
        build_model();
        drive(0);
        for (int c = 1; c <= L; c++) begin
            @(posedge clk);
            #1;
            obs_o[c] = {sel_o, busy_o, done_o, err_o};
            if (vld[c]) chk($sformatf("outs@%0d", c), 32'(obs_o[c]), 32'(exp_o[c]));
            if (c < L) drive(c);
        end

        for (int r = 1; r <= 20; r++) chk($sformatf("rst_outs@%0d", r), 32'(obs_o[r]), 32'd0);
        chk("sw_sel@18",    32'(ob(1, 18, 3)), 32'd0);
        chk("sw_sel@19",    32'(ob(1, 19, 3)), 32'd1);
        chk("sw_busy@10",   32'(ob(1, 10, 2)), 32'd0);
        chk("sw_busy@11",   32'(ob(1, 11, 2)), 32'd1);
        chk("sw_busy@34",   32'(ob(1, 34, 2)), 32'd1);
        chk("sw_busy@35",   32'(ob(1, 35, 2)), 32'd0);
        chk("sw_done@34",   32'(ob(1, 34, 1)), 32'd0);
        chk("sw_done@35",   32'(ob(1, 35, 1)), 32'd1);
        chk("sw_done@36",   32'(ob(1, 36, 1)), 32'd0);
        chk("ign_done@26",  32'(ob(1, 26, 1)), 32'd0);
        chk("ign_sel@60",   32'(ob(1, 60, 3)), 32'd1);
        chk("glt_sel@23",   32'(ob(2, 23, 3)), 32'd0);
        chk("glt_sel@24",   32'(ob(2, 24, 3)), 32'd1);
        chk("glt_done@35",  32'(ob(2, 35, 1)), 32'd0);
        chk("glt_done@40",  32'(ob(2, 40, 1)), 32'd1);
        chk("tmo_err@74",   32'(ob(3, 74, 0)), 32'd0);
        chk("tmo_err@75",   32'(ob(3, 75, 0)), 32'd1);
        chk("tmo_busy@74",  32'(ob(3, 74, 2)), 32'd1);
        chk("tmo_busy@75",  32'(ob(3, 75, 2)), 32'd0);
        chk("tmo_sel@80",   32'(ob(3, 80, 3)), 32'd0);
        for (int r = 1; r < SEG; r++) chk($sformatf("tmo_nodone@%0d", r), 32'(ob(3, r, 1)), 32'd0);
        chk("fo_sel@18",    32'(ob(4, 18, 3)), 32'd0);
        chk("fo_sel@19",    32'(ob(4, 19, 3)), 32'd1);
        chk("fo_done@35",   32'(ob(4, 35, 1)), 32'd1);
        for (int r = 1; r < SEG; r++) chk($sformatf("nofo_busy@%0d", r), 32'(ob(5, r, 2)), 32'd0);
        chk("nofo_sel@40",  32'(ob(5, 40, 3)), 32'd0);
        chk("nop_done@11",  32'(ob(6, 11, 1)), 32'd1);
        chk("nop_busy@11",  32'(ob(6, 11, 2)), 32'd0);
        chk("nop_done@12",  32'(ob(6, 12, 1)), 32'd0);
        chk("mrst_sel@25",  32'(ob(7, 25, 3)), 32'd1);
        chk("mrst_sel@26",  32'(ob(7, 26, 3)), 32'd0);
        chk("mrst_busy@26", 32'(ob(7, 26, 2)), 32'd0);
        chk("mrst_done@35", 32'(ob(7, 35, 1)), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_sel_ctrl.md
# clk_sel_ctrl

Clock-select controller that sits directly upstream of the glitch-free clock mux and drives its select input. It runs on an always-on reference clock and accepts software or automatic switch requests. Before changing select, it qualifies that the target clock has been continuously healthy. It then holds off further activity until the mux's two-flop enable handshake has settled, and reports completion or timeout.

## Interface
- STABLE_CYC, 8: consecutive cycles the target's ok flag must be high before switching; 1..255
- SETTLE_CYC, 16: reference cycles o_sel is held after a change before completion; 1..255; must cover 2 edges of the slower source clock plus 2 of the other
- TIMEOUT_CYC, 64: maximum cycles spent qualifying; 1..255; STABLE_CYC ≤ TIMEOUT_CYC
- i_clk  input  1  always-on reference clock; all logic on its rising edge
- i_rst  input  1  synchronous, active-high reset
- i_req  input  1  switch request, sampled only in IDLE
- i_req_sel  input  1  requested source: 0 = clk0, 1 = clk1
- i_auto_en  input  1  enables automatic failover
- i_clk0_ok  input  1  clk0 health flag, already synchronized to i_clk
- i_clk1_ok  input  1  clk1 health flag, already synchronized to i_clk
- o_sel  output  1  select to the clock mux, registered
- o_busy  output  1  high in QUAL and SETTLE
- o_done  output  1  one-cycle pulse: request completed
- o_err  output  1  one-cycle pulse: qualification timed out

## Operation
- Reset values: o_sel=0 (clk0), o_busy=0, o_done=0, o_err=0, state=IDLE, counters=0.
- States: IDLE, QUAL, SETTLE. Internal registers: target bit, 8-bit stability counter, 8-bit timeout counter, 8-bit settle counter.
- cur_ok = o_sel ? i_clk1_ok : i_clk0_ok. tgt_ok = target ? i_clk1_ok : i_clk0_ok.
- IDLE, evaluated in priority order:
  - i_req=1 and i_req_sel==o_sel: stay in IDLE; pulse o_done next cycle. This is a no-op.
  - i_req=1 and i_req_sel!=o_sel: target=i_req_sel; go to QUAL.
  - i_auto_en=1, cur_ok=0, and the other source's ok=1: target=~o_sel; go to QUAL.
- QUAL:
  - Each cycle, the timeout counter increments.
  - If tgt_ok=1, the stability counter increments. If tgt_ok=0, it clears to 0.
  - When the stability counter reaches STABLE_CYC: o_sel<=target; go to SETTLE.
  - Otherwise, when the timeout counter reaches TIMEOUT_CYC: pulse o_err; go to IDLE; o_sel is unchanged.
  - If both conditions occur in the same cycle, qualification wins.
- SETTLE:
  - Count SETTLE_CYC cycles, then go to IDLE with an o_done pulse.
  - Changes on the ok flags are ignored; failover is re-evaluated in IDLE.
- i_req while o_busy=1 is ignored, not queued.
- o_sel changes only on the QUAL→SETTLE transition. It never toggles twice within SETTLE_CYC cycles.
- Reset asserted mid-QUAL or mid-SETTLE: the next edge restores reset values, so o_sel=0. Any pending o_done or o_err is dropped.
- All counters clear on entry to QUAL or SETTLE. Counters are 8 bits and saturate rather than wrap.

## Timing
- A request sampled in cycle N enters QUAL in cycle N+1.
- If tgt_ok is continuously high from N+1, o_sel is visible at N+1+STABLE_CYC.
- o_busy is high from N+1 to N+STABLE_CYC+SETTLE_CYC.
- o_done and return to IDLE occur at N+1+STABLE_CYC+SETTLE_CYC; o_busy=0 in that cycle.
- Timeout: o_err occurs at N+1+TIMEOUT_CYC, and IDLE is re-entered in the same cycle.
- No-op request: o_done at N+1 and o_busy stays 0.
- A new request can be accepted in the cycle that o_done or o_err is high.
- All outputs are registered; there are no combinational paths from inputs.

## Test plan
- Reset with all inputs at 0: o_sel=0, o_busy=0, o_done=0, o_err=0 for 20 cycles.
- Defaults, i_clk1_ok=1, i_req=1 and i_req_sel=1 in cycle 10 only:
  - o_busy is high for cycles 11–34.
  - o_sel rises at cycle 19.
  - o_done pulses at cycle 35 only.
- Same request, with i_clk1_ok low for cycles 14–15 only: the stability count restarts, o_sel rises at cycle 24, and o_done pulses at cycle 40.
- Request sel=1 with i_clk1_ok=0 throughout: o_err pulses at cycle 75, o_sel stays 0, and o_done never asserts.
- Failover, with i_auto_en=1, o_sel=0, i_clk1_ok=1, and i_clk0_ok falling in cycle 10: o_sel=1 at cycle 19, then o_done. With i_auto_en=0 and the same stimulus, nothing happens.
- Corner cases:
  - i_req sel=0 while o_sel=0: o_done the next cycle.
  - A second i_req during SETTLE: ignored.
  - i_rst in cycle 25 of a switch: o_sel=0 and o_busy=0 at cycle 26, with no o_done.
